// File: rtl/i2c_regbank_pkg.sv
// Shared types and byte-map helpers for the I2C register bank.
// Included by the bank top and its pulse controller.
package i2c_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PTR,
        ST_WR,
        ST_RD
    } state_t;

    localparam int         DEF_REG_BYTES = 4;
    localparam int         DEF_NUM_RW    = 12;
    localparam int         DEF_NUM_RO    = 8;
    localparam logic [7:0] DEF_RO_BASE   = 8'h40;
    localparam int         DEF_PULSE_IDX = 11;
    localparam int         DEF_PULSE_LEN = 3;

    function automatic logic is_rw(input logic [7:0] a, input int nrw,
                                   input int rb);
        return int'(a) < nrw * rb;
    endfunction

    function automatic logic is_ro(input logic [7:0] a, input logic [7:0] base,
                                   input int nro, input int rb);
        return (int'(a) >= int'(base)) && (int'(a) < int'(base) + nro * rb);
    endfunction

    function automatic int addr_idx(input logic [7:0] a, input logic [7:0] base,
                                    input int rb);
        return (int'(a) - int'(base)) / rb;
    endfunction

    function automatic logic [1:0] addr_byte(input logic [7:0] a,
                                             input logic [7:0] base,
                                             input int rb);
        return 2'((int'(a) - int'(base)) % rb);
    endfunction

endpackage

// File: rtl/i2c_regbank_param_pulse.sv
// Hold-time counter for the self-clearing register.
// A non-zero commit loads the counter; clear fires as it runs out.
module regbank_pulse_ctrl
    import i2c_regbank_pkg::*;
#(
    parameter int PULSE_LEN = DEF_PULSE_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic zero,
    output logic clear
);

    localparam int CW = $clog2(PULSE_LEN + 1);

    logic [CW-1:0] cnt;

    // Reload on commit, otherwise count down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= zero ? '0 : CW'(PULSE_LEN);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // A fresh commit always beats the expiring pulse.
    always_comb begin
        clear = !load && (cnt == CW'(1));
    end

endmodule

// File: rtl/i2c_regbank_param.sv
// Byte-addressed register bank behind the I2C slave byte engine.
// Atomic multi-byte writes, snapshot-coherent reads, self-clearing reg.
module i2c_regbank_param
    import i2c_regbank_pkg::*;
#(
    parameter int         REG_BYTES = DEF_REG_BYTES,
    parameter int         NUM_RW    = DEF_NUM_RW,
    parameter int         NUM_RO    = DEF_NUM_RO,
    parameter logic [7:0] RO_BASE   = DEF_RO_BASE,
    parameter int         PULSE_IDX = DEF_PULSE_IDX,
    parameter int         PULSE_LEN = DEF_PULSE_LEN,
    parameter logic [NUM_RW*8*REG_BYTES-1:0] RW_RESET = '0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            data_vld,
    input  logic                            r_w,
    input  logic [7:0]                      rx_data,
    output logic [7:0]                      tx_data,
    input  logic [NUM_RO*8*REG_BYTES-1:0]   ro_regs,
    output logic [NUM_RW*8*REG_BYTES-1:0]   rw_regs,
    output logic [NUM_RW-1:0]               commit
);

    localparam int         RW       = 8 * REG_BYTES;
    localparam logic [7:0] ADDR_TOP = 8'(int'(RO_BASE) + NUM_RO * REG_BYTES - 1);
    localparam logic [1:0] LAST_B   = 2'(REG_BYTES - 1);

    state_t            state;
    state_t            state_nx;
    logic [7:0]        ptr;
    logic [7:0]        ptr_nx;
    logic              reload;
    logic [RW-1:0]     rw_q [NUM_RW];
    logic [RW-1:0]     shadow;
    logic [RW-1:0]     snap;
    logic [RW-1:0]     cm_word;
    logic [RW-1:0]     rd_word;
    logic              byte_ev;
    logic              ptr_ld;
    logic              ptr_step;
    logic              wr_hit;
    logic              wr_last;
    logic              rd_hit;
    logic              pulse_clr;
    logic [1:0]        wb;
    logic [1:0]        rb;
    logic [NUM_RW-1:0] commit_nx;

    // Transfer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: start beats stop, which beats a byte.
    always_comb begin
        state_nx = state;
        if (start) begin
            state_nx = r_w ? ST_RD : ST_PTR;
        end else if (stop) begin
            state_nx = ST_IDLE;
        end else if (data_vld && state == ST_PTR) begin
            state_nx = ST_WR;
        end
    end

    // Byte decode: pointer load/step, shadow fill and commit selection.
    always_comb begin
        byte_ev  = data_vld && !start && (state != ST_IDLE);
        ptr_ld   = byte_ev && (state == ST_PTR);
        ptr_step = byte_ev && (state == ST_WR || state == ST_RD);
        wr_hit   = byte_ev && (state == ST_WR) &&
                   is_rw(ptr, NUM_RW, REG_BYTES);
        wb       = addr_byte(ptr, 8'h00, REG_BYTES);
        wr_last  = wr_hit && (wb == LAST_B);
        cm_word  = shadow;
        cm_word[RW-8 +: 8] = rx_data;
        commit_nx = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (wr_last && addr_idx(ptr, 8'h00, REG_BYTES) == i) begin
                commit_nx[i] = 1'b1;
            end
        end
        ptr_nx = ptr;
        if (ptr_ld) begin
            ptr_nx = rx_data;
        end else if (ptr_step) begin
            ptr_nx = (ptr == ADDR_TOP) ? 8'h00 : ptr + 8'd1;
        end
    end

    // Whole-register read mux for the byte the pointer addresses.
    always_comb begin
        rd_word = '0;
        rd_hit  = 1'b0;
        rb      = '0;
        if (is_rw(ptr, NUM_RW, REG_BYTES)) begin
            rd_hit = 1'b1;
            rb     = addr_byte(ptr, 8'h00, REG_BYTES);
            for (int i = 0; i < NUM_RW; i++) begin
                if (addr_idx(ptr, 8'h00, REG_BYTES) == i) begin
                    rd_word = rw_q[i];
                end
            end
        end else if (is_ro(ptr, RO_BASE, NUM_RO, REG_BYTES)) begin
            rd_hit = 1'b1;
            rb     = addr_byte(ptr, RO_BASE, REG_BYTES);
            for (int j = 0; j < NUM_RO; j++) begin
                if (addr_idx(ptr, RO_BASE, REG_BYTES) == j) begin
                    rd_word = ro_regs[j*RW +: RW];
                end
            end
        end
    end

    // Pointer, plus a flag to refresh tx_data the cycle after it moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= '0;
            reload <= 1'b0;
        end else begin
            ptr    <= ptr_nx;
            reload <= start || ptr_ld || ptr_step;
        end
    end

    // Byte 0 snapshots the register; later bytes come from the snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
            snap    <= '0;
        end else if (reload) begin
            if (!rd_hit) begin
                tx_data <= '0;
            end else if (rb == 2'd0) begin
                snap    <= rd_word;
                tx_data <= rd_word[7:0];
            end else begin
                tx_data <= snap[rb*8 +: 8];
            end
        end
    end

    // Lower bytes collect in one shared shadow until the top byte lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (wr_hit && !wr_last) begin
            shadow[wb*8 +: 8] <= rx_data;
        end
    end

    // Committed registers and their one-cycle strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= (i == PULSE_IDX) ? '0 : RW_RESET[i*RW +: RW];
            end
            commit <= '0;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (commit_nx[i]) begin
                    rw_q[i] <= cm_word;
                end else if (i == PULSE_IDX && pulse_clr) begin
                    rw_q[i] <= '0;
                end
            end
            commit <= commit_nx;
        end
    end

    // Flatten the register array onto the output bus.
    always_comb begin
        rw_regs = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_regs[i*RW +: RW] = rw_q[i];
        end
    end

    regbank_pulse_ctrl #(
        .PULSE_LEN (PULSE_LEN)
    ) u_pulse (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (commit_nx[PULSE_IDX]),
        .zero  (cm_word == '0),
        .clear (pulse_clr)
    );

endmodule

// File: tb/tb_i2c_regbank_param.sv
// Self-checking bench for i2c_regbank_param: directed corner cases,
// a write/read-back table and randomized transfers against a byte model.
module tb_i2c_regbank_param;

    localparam logic [383:0] RST = (384'h1 << 352) | 384'h2F8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         stop;
    logic         data_vld;
    logic         r_w;
    logic [7:0]   rx_data;
    logic [7:0]   tx_data;
    logic [255:0] ro_regs;
    logic [383:0] rw_regs;
    logic [11:0]  commit;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_rw [12];
    logic [7:0]  m_sh [3];
    logic [31:0] m_snap;
    logic [7:0]  m_ptr;
    logic [7:0]  m_tx;
    int          mstate;

    typedef struct {
        logic [7:0]  ptr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [5];

    i2c_regbank_param #(
        .RW_RESET (RST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .data_vld (data_vld),
        .r_w      (r_w),
        .rx_data  (rx_data),
        .tx_data  (tx_data),
        .ro_regs  (ro_regs),
        .rw_regs  (rw_regs),
        .commit   (commit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [383:0] act,
                       input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic s, input logic st, input logic dv,
                       input logic rwv, input logic [7:0] d);
        start    = s;
        stop     = st;
        data_vld = dv;
        r_w      = rwv;
        rx_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        stop     = 1'b0;
        data_vld = 1'b0;
    endtask

    function automatic logic [31:0] slot(input int i);
        return rw_regs[i*32 +: 32];
    endfunction

    function automatic logic [383:0] flat();
        logic [383:0] f;
        for (int i = 0; i < 12; i++) f[i*32 +: 32] = m_rw[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 12; i++) m_rw[i] = RST[i*32 +: 32];
        m_rw[11] = '0;
        for (int b = 0; b < 3; b++) m_sh[b] = '0;
        m_snap = '0;
        m_ptr  = '0;
        m_tx   = '0;
        mstate = 0;
    endtask

    // Byte address -> register contents, then serve from the snapshot.
    task automatic model_load();
        int          a;
        int          b;
        logic [31:0] w;
        bit          hit;
        a   = int'(m_ptr);
        hit = 0;
        b   = 0;
        w   = '0;
        if (a < 48) begin
            w = m_rw[a/4];
            b = a % 4;
            hit = 1;
        end else if (a >= 64 && a < 96) begin
            w = ro_regs[((a-64)/4)*32 +: 32];
            b = (a - 64) % 4;
            hit = 1;
        end
        if (hit) begin
            if (b == 0) m_snap = w;
            m_tx = m_snap[b*8 +: 8];
        end else begin
            m_tx = 8'h00;
        end
    endtask

    // One bus event, then model update and checks; 0=idle 1=ptr 2=wr 3=rd.
    task automatic do_op(input logic s, input logic st, input logic dv,
                         input logic rwv, input logic [7:0] d);
        logic [11:0] m_cm;
        bit          ld;
        int          a;
        m_cm = '0;
        ld   = 0;
        drv(s, st, dv, rwv, d);
        if (s) begin
            mstate = rwv ? 3 : 1;
            ld = 1;
        end else if (st) begin
            mstate = 0;
        end else if (dv) begin
            a = int'(m_ptr);
            if (mstate == 1) begin
                m_ptr = d;
                mstate = 2;
                ld = 1;
            end else if (mstate == 2 || mstate == 3) begin
                if (mstate == 2 && a < 48) begin
                    if (a % 4 < 3) begin
                        m_sh[a%4] = d;
                    end else begin
                        m_rw[a/4] = {d, m_sh[2], m_sh[1], m_sh[0]};
                        m_cm[a/4] = 1'b1;
                    end
                end
                m_ptr = (m_ptr == 8'h5F) ? 8'h00 : m_ptr + 8'd1;
                ld = 1;
            end
        end
        chk("rnd_commit", 384'(commit), 384'(m_cm));
        chk("rnd_regs", rw_regs, flat());
        tick();
        if (ld) model_load();
        chk("rnd_tx", 384'(tx_data), 384'(m_tx));
        chk("rnd_commit_off", 384'(commit), 384'h0);
        repeat (3) tick();
        m_rw[11] = '0;
        chk("rnd_pulse_done", rw_regs, flat());
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  p;
        int          n;
        int          k;

        tbl[0] = '{8'h00, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{8'h14, 32'h01020304, 32'h01020304};
        tbl[2] = '{8'h28, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[3] = '{8'h30, 32'h12345678, 32'h00000000};
        tbl[4] = '{8'h44, 32'h55AA55AA, 32'h11213141};

        start = 0; stop = 0; data_vld = 0; r_w = 0; rx_data = 0;
        ro_regs = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();

        // Reset defaults
        chk("rst_reg0", 384'(slot(0)), 384'h2F8);
        chk("rst_pulse_forced", 384'(slot(11)), 384'h0);
        chk("rst_tx", 384'(tx_data), 384'h0);
        chk("rst_commit", 384'(commit), 384'h0);

        // Atomic write 21 03 00 00 to register 1
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h04);
        drv(0, 0, 1, 0, 8'h21);
        chk("atomic_b0", 384'(slot(1)), 384'h0);
        drv(0, 0, 1, 0, 8'h03);
        chk("atomic_b1", 384'(slot(1)), 384'h0);
        drv(0, 0, 1, 0, 8'h00);
        chk("atomic_b2", 384'(slot(1)), 384'h0);
        drv(0, 0, 1, 0, 8'h00);
        chk("atomic_commit_val", 384'(slot(1)), 384'h321);
        chk("atomic_commit_on", 384'(commit), 384'h002);
        tick();
        chk("atomic_commit_off", 384'(commit), 384'h0);
        m_rw[1] = 32'h321;

        // Coherent read of RO 0 while it changes mid-read
        ro_regs[31:0] = 32'h11223344;
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h40);
        drv(1, 0, 0, 1, 8'h00);
        tick();
        chk("coh_b0", 384'(tx_data), 384'h44);
        ro_regs[31:0] = 32'hAABBCCDD;
        drv(0, 0, 1, 1, 8'h00);
        tick();
        chk("coh_b1", 384'(tx_data), 384'h33);
        drv(0, 0, 1, 1, 8'h00);
        tick();
        chk("coh_b2", 384'(tx_data), 384'h22);
        drv(0, 0, 1, 1, 8'h00);
        tick();
        chk("coh_b3", 384'(tx_data), 384'h11);

        // Pointer wrap from ADDR_TOP, unmapped read and write
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h5F);
        drv(1, 0, 0, 1, 8'h00);
        tick();
        drv(0, 0, 1, 1, 8'h00);
        tick();
        chk("wrap_to_0", 384'(tx_data), 384'hF8);
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h30);
        drv(1, 0, 0, 1, 8'h00);
        tick();
        chk("unmapped_rd", 384'(tx_data), 384'h00);
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h30);
        drv(0, 0, 1, 0, 8'hAB);
        chk("unmapped_wr_commit", 384'(commit), 384'h0);
        chk("unmapped_wr_regs", rw_regs, flat());

        // Pulse register holds for three cycles
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h2C);
        drv(0, 0, 1, 0, 8'h01);
        drv(0, 0, 1, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h00);
        chk("pulse_c0", 384'(slot(11)), 384'h1);
        tick();
        chk("pulse_c1", 384'(slot(11)), 384'h1);
        tick();
        chk("pulse_c2", 384'(slot(11)), 384'h1);
        tick();
        chk("pulse_clr", 384'(slot(11)), 384'h0);

        // Rewrite during the pulse restarts the window
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h2C);
        drv(0, 0, 1, 0, 8'h01);
        drv(0, 0, 1, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h00);
        chk("repulse_a0", 384'(slot(11)), 384'h1);
        drv(1, 0, 0, 0, 8'h00);
        chk("repulse_a1", 384'(slot(11)), 384'h1);
        drv(0, 0, 1, 0, 8'h2F);
        chk("repulse_a2", 384'(slot(11)), 384'h1);
        drv(0, 0, 1, 0, 8'h80);
        chk("repulse_b0", 384'(slot(11)), 384'h80000001);
        tick();
        chk("repulse_b1", 384'(slot(11)), 384'h80000001);
        tick();
        chk("repulse_b2", 384'(slot(11)), 384'h80000001);
        tick();
        chk("repulse_clr", 384'(slot(11)), 384'h0);

        // start colliding with a data byte drops the byte
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h11);
        drv(1, 0, 1, 0, 8'h99);
        drv(0, 0, 1, 0, 8'h04);
        repeat (4) drv(0, 0, 1, 0, 8'h55);
        tick();
        chk("coll_reg0", 384'(slot(0)), 384'h2F8);
        chk("coll_reg1", 384'(slot(1)), 384'h55555555);
        m_rw[1] = 32'h55555555;

        // stop after two of four bytes never commits
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h08);
        drv(0, 0, 1, 0, 8'h77);
        chk("abort_c0", 384'(commit), 384'h0);
        drv(0, 0, 1, 0, 8'h88);
        chk("abort_c1", 384'(commit), 384'h0);
        drv(0, 1, 0, 0, 8'h00);
        chk("abort_c2", 384'(commit), 384'h0);
        drv(0, 0, 1, 0, 8'h99);
        chk("idle_byte_commit", 384'(commit), 384'h0);
        tick();
        chk("abort_regs", rw_regs, flat());

        // Table: write four bytes, re-point, read back four bytes
        for (int j = 0; j < 8; j++)
            ro_regs[j*32 +: 32] = 32'h10203040 + j * 32'h01010101;
        for (int t = 0; t < 5; t++) begin
            drv(1, 0, 0, 0, 8'h00);
            drv(0, 0, 1, 0, tbl[t].ptr);
            for (int b = 0; b < 4; b++)
                drv(0, 0, 1, 0, tbl[t].wdata[b*8 +: 8]);
            drv(1, 0, 0, 0, 8'h00);
            drv(0, 0, 1, 0, tbl[t].ptr);
            drv(1, 0, 0, 1, 8'h00);
            tick();
            rd[7:0] = tx_data;
            for (int b = 1; b < 4; b++) begin
                drv(0, 0, 1, 1, 8'h00);
                tick();
                rd[b*8 +: 8] = tx_data;
            end
            chk($sformatf("table_%0d", t), 384'(rd), 384'(tbl[t].exp_rd));
        end

        // Reset in the middle of a read
        drv(1, 0, 0, 0, 8'h00);
        drv(0, 0, 1, 0, 8'h40);
        drv(1, 0, 0, 1, 8'h00);
        tick();
        chk("midrst_pre_tx", 384'(tx_data), 384'h40);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_tx", 384'(tx_data), 384'h0);
        chk("midrst_regs", rw_regs, flat());
        chk("midrst_commit", 384'(commit), 384'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        drv(0, 0, 1, 1, 8'h00);
        tick();
        chk("midrst_idle_tx", 384'(tx_data), 384'h0);

        // Randomized transfers against the byte model
        for (int j = 0; j < 8; j++) ro_regs[j*32 +: 32] = $urandom;
        for (int t = 0; t < 120; t++) begin
            k = $urandom_range(0, 3);
            p = 8'($urandom_range(0, 8'h63));
            n = $urandom_range(1, 6);
            if (k <= 1) begin
                do_op(1, 0, 0, 0, 8'h00);
                do_op(0, 0, 1, 0, p);
                for (int b = 0; b < n; b++)
                    do_op(0, 0, 1, 0, 8'($urandom));
            end else begin
                if ($urandom_range(0, 1) == 1) begin
                    do_op(1, 0, 0, 0, 8'h00);
                    do_op(0, 0, 1, 0, p);
                end
                do_op(1, 0, 0, 1, 8'h00);
                for (int b = 0; b < n; b++) begin
                    if ($urandom_range(0, 1) == 1)
                        ro_regs[$urandom_range(0, 7)*32 +: 32] = $urandom;
                    do_op(0, 0, 1, 1, 8'($urandom));
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                do_op(0, 1, 0, r_w, 8'h00);
                if ($urandom_range(0, 3) == 0)
                    do_op(0, 0, 1, r_w, 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
